decoder_arbiter: RTL and testbench

//   Shares one 64-bit Decoder core between NREQ requesters. Round-robin picks a pending ciphertext,

---
 rtl/decoder_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_decoder_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_arbiter
//   Shares one Decoder core between NREQ requesters. A round-robin pointer
//   picks a pending ciphertext, the block launches the Decoder, waits for done
//   and returns the plaintext on a single response channel tagged with the id
//   of the requester that owns it. Only one job is in flight at a time.
//
// Optional feature (compile-time macro DEC_ARB_TIMEOUT_EN):
//   When defined, a 16-bit watchdog aborts a job that has spent TIMEOUT
//   cycles in WAIT. The response then carries resp_error=1 and a zero
//   plaintext. When undefined, WAIT waits for dec_done indefinitely and
//   resp_error is always 0.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
//   edge where valid and ready are both 1. A producer holds valid and data
//   stable until it sees ready. ready may depend combinationally on valid
//   (req_ready does), valid never depends on ready.
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous, active-low reset
//   req_valid       per-requester ciphertext valid
//   req_ready       per-requester accept (one-hot or zero, only in IDLE)
//   req_ciphertext  requester i on bits [i*DW +: DW]
//   resp_valid      result available (registered)
//   resp_ready      consumer accepts result
//   resp_id         index of the requester owning the result
//   resp_plaintext  decoded data
//   resp_error      watchdog abort, plaintext invalid
//   dec_start       one-cycle Decoder start pulse (registered)
//   dec_ciphertext  ciphertext presented to the Decoder (registered)
//   dec_done        Decoder done, only observed in WAIT
//   dec_plaintext   Decoder result, captured when dec_done is seen
//   dbg_state       current FSM state: 0 IDLE, 1 LAUNCH, 2 WAIT, 3 RESP
// -----------------------------------------------------------------------------
module decoder_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 64,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_ciphertext,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic [DW-1:0]      resp_plaintext,
  output logic               resp_error,
  output logic               dec_start,
  output logic [DW-1:0]      dec_ciphertext,
  input  logic               dec_done,
  input  logic [DW-1:0]      dec_plaintext,
  output logic [1:0]         dbg_state
);

  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT < 1 || TIMEOUT > 65535)
  begin : g_bad_params
    $error("decoder_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic [DW-1:0]   dec_ct_q;
  logic            dec_start_q;
  logic            resp_valid_q;
  logic [IDW-1:0]  resp_id_q;
  logic [DW-1:0]   resp_pt_q;
  logic            resp_err_q;
`ifdef DEC_ARB_TIMEOUT_EN
  logic [15:0]     cnt_q;
`endif

  // Round-robin search starting at ptr+1. Indices above the pointer win
  // (lowest first); otherwise wrap to the lowest valid index at or below it.
  // The descending loop leaves the smallest matching index in each half.
  logic            hi_vld, lo_vld, grant_vld_d;
  logic [IDW-1:0]  hi_idx, lo_idx, grant_idx_d;
  logic [DW-1:0]   grant_ct_d;

  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDW'(i) > ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = IDW'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = IDW'(i);
        end
      end
    end
    grant_vld_d = hi_vld | lo_vld;
    grant_idx_d = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    grant_ct_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_idx_d) grant_ct_d = req_ciphertext[i*DW +: DW];
    end
  end

  // Accept is only offered from IDLE, and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset && state_q == S_IDLE && grant_vld_d) begin
      for (int i = 0; i < NREQ; i++) begin
        req_ready[i] = (IDW'(i) == grant_idx_d);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= IDW'(NREQ - 1);
      id_q         <= '0;
      dec_ct_q     <= '0;
      dec_start_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_pt_q    <= '0;
      resp_err_q   <= 1'b0;
`ifdef DEC_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            dec_ct_q    <= grant_ct_d;
            id_q        <= grant_idx_d;
            ptr_q       <= grant_idx_d;
            dec_start_q <= 1'b1;
            state_q     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          dec_start_q <= 1'b0;
          state_q     <= S_WAIT;
`ifdef DEC_ARB_TIMEOUT_EN
          cnt_q       <= '0;
`endif
        end
        S_WAIT: begin
          // dec_done beats an expiry on the same cycle.
          if (dec_done) begin
            resp_pt_q    <= dec_plaintext;
            resp_id_q    <= id_q;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
`ifdef DEC_ARB_TIMEOUT_EN
          else if (cnt_q == 16'(TIMEOUT - 1)) begin
            resp_pt_q    <= '0;
            resp_id_q    <= id_q;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dec_start      = dec_start_q;
  assign dec_ciphertext = dec_ct_q;
  assign resp_valid     = resp_valid_q;
  assign resp_id        = resp_id_q;
  assign resp_plaintext = resp_pt_q;
  assign resp_error     = resp_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_decoder_arbiter.sv
module tb_decoder_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int IDW  = 2;
  localparam int TMO  = 16;
  localparam int EW   = 1 + IDW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_ciphertext;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [DW-1:0]      resp_plaintext;
  logic               resp_error;
  logic               dec_start;
  logic [DW-1:0]      dec_ciphertext;
  logic               dec_done;
  logic [DW-1:0]      dec_plaintext;
  logic [1:0]         dbg_state;

  logic [DW-1:0] rct [NREQ];
  always_comb begin
    for (int i = 0; i < NREQ; i++) req_ciphertext[i*DW +: DW] = rct[i];
  end

  decoder_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_ciphertext(req_ciphertext),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_plaintext(resp_plaintext), .resp_error(resp_error),
    .dec_start(dec_start), .dec_ciphertext(dec_ciphertext),
    .dec_done(dec_done), .dec_plaintext(dec_plaintext),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // The Decoder's transform (stands in for the real cipher core).
  function automatic logic [DW-1:0] dec_f(input logic [DW-1:0] c);
    return {c[31:0], c[63:32]} ^ 64'h0123_4567_89ab_cdef;
  endfunction

  // ---------------- Decoder model ----------------
  int            dec_lat = 3;
  bit            dec_lat_rand = 0;
  bit            dec_never = 0;
  bit            stray = 0;
  int            dm_cnt = 0;
  bit            dm_busy = 0;
  logic [DW-1:0] dm_ct;

  initial begin
    dec_done = 1'b0;
    dec_plaintext = '0;
    forever begin
      @(posedge clk);
      #1;
      dec_done = 1'b0;
      dec_plaintext = {$urandom, $urandom};
      if (!reset) begin
        dm_busy = 0;
      end else begin
        if (dm_busy) begin
          dm_cnt--;
          if (dm_cnt == 0) begin
            dm_busy = 0;
            dec_done = 1'b1;
            dec_plaintext = dec_f(dm_ct);
          end
        end
        if (dec_start && !dec_never) begin
          dm_busy = 1;
          dm_ct = dec_ciphertext;
          dm_cnt = dec_lat_rand ? int'($urandom_range(12, 1)) : dec_lat;
        end
        if (stray) dec_done = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  // Expected responses packed as {error, id, plaintext}.
  logic [EW-1:0] exp_q[$];
  int            grant_log[$];
  int            rr_ptr = NREQ - 1;
  bit            model_busy = 0;
  bit            launch_pending = 0;
  bit            waiting = 0;
  bit            exp_resp_valid = 0;
  int            wait_cnt = 0;
  int            waits [NREQ];
  int            resp_count = 0;
  int            start_count = 0;
  logic [DW-1:0] last_ct;
  logic [IDW-1:0] last_id;
  logic [DW-1:0]  last_pt;
  logic           last_err;
  logic [NREQ-1:0] exp_ready;
  int            mon_g;
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      grant_log.delete();
      rr_ptr = NREQ - 1;
      model_busy = 0;
      launch_pending = 0;
      waiting = 0;
      exp_resp_valid = 0;
      wait_cnt = 0;
      resp_count = 0;
      start_count = 0;
      for (int i = 0; i < NREQ; i++) waits[i] = 0;
    end else begin
      // Which requester should be accepted right now, if any.
      exp_ready = '0;
      mon_g = -1;
      if (!model_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (mon_g < 0 && req_valid[(rr_ptr + k) % NREQ]) mon_g = (rr_ptr + k) % NREQ;
        end
      end
      if (mon_g >= 0) exp_ready[mon_g] = 1'b1;
      chk("req_ready", req_ready, exp_ready);

      chk("dec_start", dec_start, launch_pending);
      if (launch_pending) chk("dec_ciphertext", dec_ciphertext, last_ct);

      chk("resp_valid", resp_valid, exp_resp_valid);
      if (exp_resp_valid && resp_valid) begin
        mon_e = exp_q[0];
        chk("resp_id", resp_id, mon_e[DW +: IDW]);
        chk("resp_plaintext", resp_plaintext, mon_e[DW-1:0]);
        chk("resp_error", resp_error, mon_e[EW-1]);
        if (resp_ready) begin
          void'(exp_q.pop_front());
          resp_count++;
          last_id = resp_id;
          last_pt = resp_plaintext;
          last_err = resp_error;
          exp_resp_valid = 0;
          model_busy = 0;
        end
      end

      if (waiting) begin
        wait_cnt++;
        if (dec_done) begin
          exp_resp_valid = 1;
          waiting = 0;
        end
`ifdef DEC_ARB_TIMEOUT_EN
        else if (wait_cnt == TMO) begin
          mon_e = exp_q.pop_front();
          exp_q.push_front({1'b1, mon_e[DW +: IDW], {DW{1'b0}}});
          exp_resp_valid = 1;
          waiting = 0;
        end
`endif
      end

      if (launch_pending) begin
        waiting = 1;
        wait_cnt = 0;
        start_count++;
      end
      launch_pending = 0;

      if (mon_g >= 0) begin
        chk("fairness", waits[mon_g] <= NREQ - 1, 1'b1);
        waits[mon_g] = 0;
        for (int i = 0; i < NREQ; i++) if (i != mon_g && req_valid[i]) waits[i]++;
        grant_log.push_back(mon_g);
        rr_ptr = mon_g;
        model_busy = 1;
        last_ct = rct[mon_g];
        exp_q.push_back({1'b0, IDW'(mon_g), dec_f(rct[mon_g])});
        launch_pending = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [NREQ-1:0] en_mask = '0;
  int              density = 0;
  bit              rdy_random = 0;

  // One clock: note transfers at the falling edge, update requesters after
  // the rising edge so the DUT has consumed the accepted data.
  task automatic tick();
    logic [NREQ-1:0] xfer;
    @(negedge clk);
    xfer = req_valid & req_ready;
    @(posedge clk);
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && en_mask[i] && int'($urandom_range(99, 0)) < density) begin
        req_valid[i] = 1'b1;
        rct[i] = {$urandom, $urandom};
      end
    end
    if (rdy_random) resp_ready = ($urandom_range(99, 0) < 70);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", req_ready, '0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_id", resp_id, '0);
    chk("rst_resp_plaintext", resp_plaintext, '0);
    chk("rst_resp_error", resp_error, 1'b0);
    chk("rst_dec_start", dec_start, 1'b0);
    chk("rst_dec_ciphertext", dec_ciphertext, '0);
    chk("rst_state", dbg_state, 2'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic wait_resp(input string tag, input int budget);
    int c0 = resp_count;
    int n = 0;
    while (resp_count == c0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, resp_count != c0, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int s0;
    int g0;
    int exp_order [5];
    logic [DW-1:0] ct;
    exp_order = '{0, 1, 2, 3, 0};
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) rct[i] = '0;

    // 1: single job from requester 0, Decoder latency 10
    do_reset();
    dec_lat = 10;
    rct[0] = 64'h3cf72a8b7518e6f7;
    req_valid[0] = 1'b1;
    wait_resp("t1_wait", 40);
    repeat (3) tick();
    chk("t1_resp_count", resp_count, 1);
    chk("t1_start_count", start_count, 1);
    chk("t1_id", last_id, 0);
    chk("t1_plaintext", last_pt, dec_f(64'h3cf72a8b7518e6f7));
    chk("t1_error", last_err, 1'b0);

    // 2: all four valid from reset -> grants 0,1,2,3,0
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) rct[i] = {$urandom, $urandom};
    en_mask = '1;
    density = 100;
    dec_lat = 3;
    do_reset();
    n = 0;
    while (grant_log.size() < 5 && n < 200) begin
      tick();
      n++;
    end
    chk("t2_grant_count", grant_log.size() >= 5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k < grant_log.size()) chk("t2_rr_order", grant_log[k], exp_order[k]);
    end

    // 3: response backpressure holds everything for 20 cycles
    en_mask = '0;
    density = 0;
    req_valid = '0;
    do_reset();
    rct[0] = {$urandom, $urandom};
    rct[1] = {$urandom, $urandom};
    req_valid = 4'b0011;
    resp_ready = 1'b0;
    dec_lat = 2;
    n = 0;
    while (!resp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("t3_resp_valid", resp_valid, 1'b1);
    s0 = start_count;
    g0 = grant_log.size();
    repeat (20) tick();
    chk("t3_no_start", start_count, s0);
    chk("t3_no_grant", grant_log.size(), g0);
    resp_ready = 1'b1;
    tick();
    tick();
    chk("t3_next_grant", grant_log.size(), g0 + 1);
    chk("t3_first_id", last_id, 0);
    wait_resp("t3_second_wait", 20);
    chk("t3_second_id", last_id, 1);

    // 4: reset while the job sits in WAIT
    req_valid = '0;
    do_reset();
    rct[0] = {$urandom, $urandom};
    req_valid[0] = 1'b1;
    dec_lat = 30;
    repeat (6) tick();
    chk("t4_in_wait", dbg_state, 2'd2);
    do_reset();
    repeat (40) tick();
    chk("t4_no_resp", resp_count, 0);
    ct = {$urandom, $urandom};
    rct[0] = ct;
    req_valid[0] = 1'b1;
    dec_lat = 5;
    wait_resp("t4_wait", 30);
    chk("t4_id", last_id, 0);
    chk("t4_plaintext", last_pt, dec_f(ct));

    // 5: stray dec_done while IDLE
    repeat (2) tick();
    chk("t5_idle", dbg_state, 2'd0);
    s0 = resp_count;
    stray = 1;
    tick();
    stray = 0;
    repeat (5) tick();
    chk("t5_no_resp", resp_count, s0);
    chk("t5_resp_valid", resp_valid, 1'b0);
    chk("t5_still_idle", dbg_state, 2'd0);

    // 6: Decoder never finishes
    req_valid = '0;
    do_reset();
    dec_never = 1;
    rct[2] = {$urandom, $urandom};
    req_valid[2] = 1'b1;
`ifdef DEC_ARB_TIMEOUT_EN
    wait_resp("t6_wait", 60);
    chk("t6_id", last_id, 2);
    chk("t6_plaintext", last_pt, '0);
    chk("t6_error", last_err, 1'b1);
`else
    repeat (60) tick();
    chk("t6_stuck_wait", dbg_state, 2'd2);
    chk("t6_no_resp", resp_count, 0);
    chk("t6_resp_valid", resp_valid, 1'b0);
`endif
    dec_never = 0;

    // Random traffic, random Decoder latency, random consumer readiness
    req_valid = '0;
    do_reset();
    en_mask = '1;
    density = 30;
    rdy_random = 1;
    dec_lat_rand = 1;
    repeat (1500) tick();
    rdy_random = 0;
    en_mask = '0;
    resp_ready = 1'b1;
    repeat (60) tick();
    chk("rand_progress", resp_count > 50, 1'b1);
    chk("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
